// File: rtl/strobe_gen.sv
// Programmable countdown timer producing single-cycle enable strobes,
// either periodically every P_eff cycles or once (one-shot).
module strobe_gen #(
    parameter int unsigned w = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         oneshot,
    input  logic [w-1:0] period,
    output logic         strobe,
    output logic         busy,
    output logic [w-1:0] remaining
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [w-1:0] ONE = {{(w-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [w-1:0] cnt_q, cnt_d;
    logic [w-1:0] period_q, period_d;
    logic         oneshot_q, oneshot_d;
    logic         strobe_q, strobe_d;
    logic [w-1:0] p_eff;

    assign p_eff = (period == '0) ? ONE : period;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        strobe_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start) begin
            // A restart abandons the current period without a strobe.
            period_d  = p_eff;
            oneshot_d = oneshot;
            cnt_d     = p_eff - ONE;
            state_d   = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_q == '0) begin
                        strobe_d = 1'b1;
                        if (oneshot_q) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = period_q - ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= ONE;
            oneshot_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            strobe_q  <= strobe_d;
        end
    end

    assign strobe    = strobe_q;
    assign busy      = (state_q == RUN);
    assign remaining = cnt_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Directed bench for strobe_gen: each step pushes the expected
// {strobe, busy, remaining} after the next edge and checks it #1 later.
module tb_strobe_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         oneshot = 1'b0;
    logic [W-1:0] period = '0;
    logic         strobe;
    logic         busy;
    logic [W-1:0] remaining;

    logic [W+1:0] exp_q[$];
    int           pass_cnt = 0;
    int           check_cnt = 0;

    strobe_gen #(.w(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .period    (period),
        .strobe    (strobe),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic r, input logic st, input logic sp,
                       input logic os, input logic [W-1:0] per,
                       input logic es, input logic eb, input logic [W-1:0] er);
        logic [W+1:0] exp_v;
        logic [W+1:0] obs_v;
        rst = r; start = st; stop = sp; oneshot = os; period = per;
        exp_q.push_back({es, eb, er});
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        exp_v = exp_q.pop_front();
        obs_v = {strobe, busy, remaining};
        check_cnt++;
        assert (obs_v === exp_v) pass_cnt++;
        else $error("FAIL %s: strobe/busy/remaining got %0b/%0b/%0d expected %0b/%0b/%0d",
                    tag, obs_v[W+1], obs_v[W], obs_v[W-1:0],
                    exp_v[W+1], exp_v[W], exp_v[W-1:0]);
    endtask

    task automatic idle(input string tag, input int n, input logic eb, input logic [W-1:0] er);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, eb, er);
    endtask

    initial begin
        // reset state
        cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        idle("post_reset_idle", 2, 1'b0, '0);

        // periodic, period 4
        cyc("per4_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 1'b1, 16'd3);
        for (int k = 1; k <= 12; k++)
            cyc("per4_run", 1'b0, 1'b0, 1'b0, 1'b0, '0, (k % 4 == 0), 1'b1, W'(3 - (k % 4)));
        cyc("per4_stop", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // one-shot, period 5
        cyc("os5_start", 1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 1'b0, 1'b1, 16'd4);
        for (int k = 1; k <= 4; k++)
            cyc("os5_count", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, W'(4 - k));
        cyc("os5_strobe", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle("os5_quiet", 20, 1'b0, '0);

        // period 0 and 1 in periodic mode: continuous strobe
        cyc("p0_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, '0);
        for (int k = 1; k <= 5; k++)
            cyc("p0_run", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, '0);
        cyc("p0_stop", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cyc("p1_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1, '0);
        for (int k = 1; k <= 5; k++)
            cyc("p1_run", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, '0);
        cyc("p1_stop", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        idle("p1_after_stop", 2, 1'b0, '0);

        // restart at remaining=2
        cyc("rs_start10", 1'b0, 1'b1, 1'b0, 1'b0, 16'd10, 1'b0, 1'b1, 16'd9);
        for (int k = 1; k <= 7; k++)
            cyc("rs_count10", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, W'(9 - k));
        cyc("rs_restart3", 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 16'd2);
        cyc("rs_count3a", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd1);
        cyc("rs_count3b", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd0);
        cyc("rs_strobe", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 16'd2);
        cyc("rs_stop", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // stop and start together
        cyc("ss_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 1'b1, 16'd3);
        cyc("ss_both", 1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, '0);
        idle("ss_idle", 2, 1'b0, '0);

        // stop on terminal count
        cyc("stc_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 16'd1);
        cyc("stc_count", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd0);
        cyc("stc_stop", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        idle("stc_idle", 2, 1'b0, '0);

        // start on terminal count, new run is one-shot period 3
        cyc("rtc_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 16'd1);
        cyc("rtc_count", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd0);
        cyc("rtc_restart", 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 16'd2);
        cyc("rtc_count3a", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd1);
        cyc("rtc_count3b", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd0);
        cyc("rtc_strobe", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle("rtc_quiet", 4, 1'b0, '0);

        // reset mid-run at remaining=1
        cyc("rm_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd6, 1'b0, 1'b1, 16'd5);
        for (int k = 1; k <= 4; k++)
            cyc("rm_count", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, W'(5 - k));
        cyc("rm_reset", 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        idle("rm_quiet", 8, 1'b0, '0);

        // full-width period
        cyc("max_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE);
        for (int k = 1; k <= 65535; k++)
            cyc("max_run", 1'b0, 1'b0, 1'b0, 1'b0, '0, (k == 65535), 1'b1,
                (k == 65535) ? 16'hFFFE : W'(65534 - k));
        cyc("max_stop", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        check_cnt++;
        assert (exp_q.size() == 0) pass_cnt++;
        else $error("FAIL sb_drain: queue depth got %0d expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
